// File: rtl/riscv_pkg.sv
// Shared RV32 encoding constants: format codes, the opcodes the encoder is
// normally fed with, instruction field positions, and immediate range helpers.
package riscv_pkg;

    localparam int FMT_CODE_W = 3;

    localparam logic [FMT_CODE_W-1:0] FMT_R  = 3'd0;
    localparam logic [FMT_CODE_W-1:0] FMT_I  = 3'd1;
    localparam logic [FMT_CODE_W-1:0] FMT_S  = 3'd2;
    localparam logic [FMT_CODE_W-1:0] FMT_SB = 3'd3;
    localparam logic [FMT_CODE_W-1:0] FMT_U  = 3'd4;
    localparam logic [FMT_CODE_W-1:0] FMT_UJ = 3'd5;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    // Low bit of each fixed-position field; the decoder uses the same numbers.
    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

    // True when v[31:lsb] are all ones or all zeros (value sign-extends from bit lsb).
    function automatic logic all_equal_from(input logic [31:0] v, input int lsb);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << lsb;
        return ((v & mask) == mask) || ((v & mask) == 32'h0);
    endfunction

    // True when v[31:lsb] are all zeros (value zero-extends from bit lsb).
    function automatic logic high_zero_from(input logic [31:0] v, input int lsb);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << lsb;
        return (v & mask) == 32'h0;
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-in / word-out bundle of the instruction encoder.
// Handshake: on each side a word moves on a rising clock edge where valid and
// ready are both high; a producer holds valid and its payload stable until that
// edge, and ready never depends combinationally on valid.
interface inst_encoder_if;
    import riscv_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [FMT_CODE_W-1:0] in_fmt;
    logic [6:0]            in_opcode;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [2:0]            in_funct3;
    logic [6:0]            in_funct7;
    logic [31:0]           in_imm;
    logic                  in_sign_ext;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_inst;
    logic                  out_err;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
               in_funct7, in_imm, in_sign_ext, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
               in_funct7, in_imm, in_sign_ext, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );

endinterface

// File: rtl/inst_imm_range_check.sv
// Combinational check that an immediate survives encode-then-decode for its
// format. Formats without an immediate (and invalid codes) always report ok.
module inst_imm_range_check
    import riscv_pkg::*;
(
    input  logic [FMT_CODE_W-1:0] fmt,
    input  logic [31:0]           imm,
    input  logic                  sign_ext,
    output logic                  ok
);

    // Per-format round-trip rule on the upper bits and the implied-zero LSB.
    always_comb begin
        ok = 1'b1;
        case (fmt)
            FMT_I, FMT_S: ok = sign_ext ? all_equal_from(imm, 11) : high_zero_from(imm, 12);
            FMT_SB:       ok = !imm[0] && (sign_ext ? all_equal_from(imm, 12) : high_zero_from(imm, 13));
            FMT_UJ:       ok = !imm[0] && all_equal_from(imm, 20);
            FMT_U:        ok = (imm[11:0] == 12'h000);
            default:      ok = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// RV32 instruction assembler: decoded fields + immediate in, packed 32-bit word
// out through a two-stage pipeline (S1 holds fields, S2 holds the word).
// Build option: define IMM_RANGE_CHECK_EN to flag immediates that would not
// decode back to the same value; otherwise excess immediate bits are dropped.
module inst_encoder
    import riscv_pkg::*;
#(
    parameter bit ERR_ZERO_INST = 1'b1,
    parameter int FMT_W         = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_encoder_if.slave bus
);

    logic             s1_valid;
    logic [FMT_W-1:0] s1_fmt;
    logic [6:0]       s1_opcode;
    logic [4:0]       s1_rd;
    logic [4:0]       s1_rs1;
    logic [4:0]       s1_rs2;
    logic [2:0]       s1_funct3;
    logic [6:0]       s1_funct7;
    logic [31:0]      s1_imm;
    logic             s1_err;

    logic             s2_valid;
    logic [31:0]      s2_inst;
    logic             s2_err;

    logic             s2_adv;
    logic             in_ready;
    logic             range_ok;
    logic             fmt_bad;
    logic [31:0]      word;

    assign s2_adv   = !s2_valid || bus.out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign fmt_bad  = (bus.in_fmt > FMT_UJ);

`ifdef IMM_RANGE_CHECK_EN
    inst_imm_range_check u_range (
        .fmt      (bus.in_fmt),
        .imm      (bus.in_imm),
        .sign_ext (bus.in_sign_ext),
        .ok       (range_ok)
    );
`else
    logic unused_sign_ext;
    assign unused_sign_ext = bus.in_sign_ext;
    assign range_ok        = 1'b1;
`endif

    // S1: capture fields and the error verdict on an input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= '0;
            s1_opcode <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_funct3 <= '0;
            s1_funct7 <= '0;
            s1_imm    <= '0;
            s1_err    <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (in_ready && bus.in_valid) begin
                s1_fmt    <= bus.in_fmt;
                s1_opcode <= bus.in_opcode;
                s1_rd     <= bus.in_rd;
                s1_rs1    <= bus.in_rs1;
                s1_rs2    <= bus.in_rs2;
                s1_funct3 <= bus.in_funct3;
                s1_funct7 <= bus.in_funct7;
                s1_imm    <= bus.in_imm;
                s1_err    <= fmt_bad || !range_ok;
            end
        end
    end

    // Packing mux: place fixed fields, then scatter the immediate per format.
    always_comb begin
        word = 32'h0;
        word[OPCODE_LSB +: 7] = s1_opcode;
        case (s1_fmt)
            FMT_R: begin
                word[RD_LSB +: 5]     = s1_rd;
                word[FUNCT3_LSB +: 3] = s1_funct3;
                word[RS1_LSB +: 5]    = s1_rs1;
                word[RS2_LSB +: 5]    = s1_rs2;
                word[FUNCT7_LSB +: 7] = s1_funct7;
            end
            FMT_I: begin
                word[RD_LSB +: 5]     = s1_rd;
                word[FUNCT3_LSB +: 3] = s1_funct3;
                word[RS1_LSB +: 5]    = s1_rs1;
                word[31:20]           = s1_imm[11:0];
            end
            FMT_S: begin
                word[11:7]            = s1_imm[4:0];
                word[FUNCT3_LSB +: 3] = s1_funct3;
                word[RS1_LSB +: 5]    = s1_rs1;
                word[RS2_LSB +: 5]    = s1_rs2;
                word[31:25]           = s1_imm[11:5];
            end
            FMT_SB: begin
                word[7]               = s1_imm[11];
                word[11:8]            = s1_imm[4:1];
                word[FUNCT3_LSB +: 3] = s1_funct3;
                word[RS1_LSB +: 5]    = s1_rs1;
                word[RS2_LSB +: 5]    = s1_rs2;
                word[30:25]           = s1_imm[10:5];
                word[31]              = s1_imm[12];
            end
            FMT_U: begin
                word[RD_LSB +: 5]     = s1_rd;
                word[31:12]           = s1_imm[31:12];
            end
            FMT_UJ: begin
                word[RD_LSB +: 5]     = s1_rd;
                word[19:12]           = s1_imm[19:12];
                word[20]              = s1_imm[11];
                word[30:21]           = s1_imm[10:1];
                word[31]              = s1_imm[20];
            end
            default: word = 32'h0;
        endcase
        if (s1_err && ERR_ZERO_INST) begin
            word = 32'h0;
        end
    end

    // S2: register the assembled word; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_inst  <= 32'h0;
            s2_err   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_inst <= word;
                s2_err  <= s1_err;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.out_inst  = s2_inst;
    assign bus.out_err   = s2_err;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed vectors with hand-computed words, an
// arithmetic reference model feeding an expected queue, and a per-cycle
// output monitor (order, hold-under-stall, latency).
module tb_inst_encoder;
    import riscv_pkg::*;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        sext;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inst_encoder_if bus();

    inst_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [32:0] exp_q[$];
    int          acc_q[$];
    bit          check_lat  = 1'b1;
    bit          head_seen  = 1'b0;
    bit          prev_stall = 1'b0;
    logic [32:0] prev_out;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm, input logic sext);
        vec_t v;
        v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.sext = sext;
        return v;
    endfunction

    // Reference: build the word with shifts and masks straight from the format table.
    function automatic logic [31:0] model_inst(input vec_t v);
        logic [31:0] op, rd, rs1, rs2, f3, f7, imm, r;
        op = 32'(v.op); rd = 32'(v.rd); rs1 = 32'(v.rs1); rs2 = 32'(v.rs2);
        f3 = 32'(v.f3); f7 = 32'(v.f7); imm = v.imm;
        case (v.fmt)
            3'd0: r = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            3'd1: r = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            3'd2: r = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                      | ((imm & 32'h1F) << 7) | op;
            3'd3: r = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                      | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                      | (((imm >> 11) & 1) << 7) | op;
            3'd4: r = (imm & 32'hFFFF_F000) | (rd << 7) | op;
            3'd5: r = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Reference error: invalid format, plus numeric range rules when range checking is built in.
    function automatic logic model_err(input vec_t v);
        logic bad;
        int   s;
        s   = $signed(v.imm);
        bad = (v.fmt > 3'd5);
`ifdef IMM_RANGE_CHECK_EN
        case (v.fmt)
            3'd1, 3'd2: bad = v.sext ? (s < -2048 || s > 2047) : (v.imm > 32'd4095);
            3'd3: bad = (v.imm % 2 != 0) || (v.sext ? (s < -4096 || s > 4095) : (v.imm > 32'd8191));
            3'd4: bad = (v.imm % 4096 != 0);
            3'd5: bad = (v.imm % 2 != 0) || (s < -(1 << 20)) || (s > (1 << 20) - 1);
            default: ;
        endcase
`endif
        return bad;
    endfunction

    function automatic logic [32:0] model(input vec_t v);
        logic e;
        e = model_err(v);
        return {e, e ? 32'h0 : model_inst(v)};
    endfunction

    function automatic vec_t bus_vec();
        return mkv(bus.in_fmt, bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2,
                   bus.in_funct3, bus.in_funct7, bus.in_imm, bus.in_sign_ext);
    endfunction

    // Compare process: runs each falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            head_seen  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(bus.out_valid), 64'd1);
                if (bus.out_valid) check("stall_hold", 64'({bus.out_err, bus.out_inst}), 64'(prev_out));
            end
            if (bus.out_valid && !head_seen && check_lat && acc_q.size() > 0)
                check("latency", 64'(cyc - acc_q[0]), 64'd2);
            if (bus.out_valid) head_seen = 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: actual %h required none", {bus.out_err, bus.out_inst});
                end else begin
                    e = exp_q.pop_front();
                    void'(acc_q.pop_front());
                    check("out_word", 64'({bus.out_err, bus.out_inst}), 64'(e));
                end
                head_seen = 1'b0;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.out_err, bus.out_inst};
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus_vec()));
                acc_q.push_back(cyc);
            end
        end
    end

    task automatic drive_fields(input vec_t v);
        bus.in_fmt      = v.fmt;
        bus.in_opcode   = v.op;
        bus.in_rd       = v.rd;
        bus.in_rs1      = v.rs1;
        bus.in_rs2      = v.rs2;
        bus.in_funct3   = v.f3;
        bus.in_funct7   = v.f7;
        bus.in_imm      = v.imm;
        bus.in_sign_ext = v.sext;
    endtask

    // Offer one word (called just after a rising edge); pins the model to the literal first.
    task automatic send(input vec_t v, input logic [31:0] exp_inst, input logic exp_err);
        bit acc;
        int n;
        check("model_pin", 64'(model(v)), 64'({exp_err, exp_inst}));
        drive_fields(v);
        bus.in_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: actual in_ready=0 required 1 within 40 cycles");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        vec_t          addi, sw, lui, beq, jal, add, sub, addi_neg, addi_big, fmt6, fmt7, li2, li3;
        logic [31:0]   big_inst;
        logic          big_err;
        logic [11:0]   pat;

        addi     = mkv(FMT_I,  OP_IMM,    5'd1, 5'd2, 5'd0, 3'd0, 7'd0,  32'd5,         1'b1);
        sw       = mkv(FMT_S,  OP_STORE,  5'd0, 5'd2, 5'd5, 3'd2, 7'd0,  32'd8,         1'b1);
        lui      = mkv(FMT_U,  OP_LUI,    5'd3, 5'd0, 5'd0, 3'd0, 7'd0,  32'h1234_5000, 1'b0);
        beq      = mkv(FMT_SB, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,  32'hFFFF_FFFC, 1'b1);
        jal      = mkv(FMT_UJ, OP_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'h800,       1'b1);
        add      = mkv(FMT_R,  7'h33,     5'd3, 5'd1, 5'd2, 3'd0, 7'd0,  32'hDEAD_BEEF, 1'b0);
        sub      = mkv(FMT_R,  7'h33,     5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,         1'b0);
        addi_neg = mkv(FMT_I,  OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'hFFFF_FFFF, 1'b1);
        addi_big = mkv(FMT_I,  OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'h800,       1'b1);
        fmt6     = mkv(3'd6,   OP_IMM,    5'd1, 5'd2, 5'd3, 3'd1, 7'd1,  32'd4,         1'b0);
        fmt7     = mkv(3'd7,   OP_JAL,    5'd7, 5'd7, 5'd7, 3'd7, 7'd7,  32'd0,         1'b1);
        li2      = mkv(FMT_I,  OP_IMM,    5'd2, 5'd0, 5'd0, 3'd0, 7'd0,  32'd1,         1'b1);
        li3      = mkv(FMT_I,  OP_IMM,    5'd3, 5'd0, 5'd0, 3'd0, 7'd0,  32'd2,         1'b1);
`ifdef IMM_RANGE_CHECK_EN
        big_inst = 32'h0000_0000;
        big_err  = 1'b1;
`else
        big_inst = 32'h8000_0093;
        big_err  = 1'b0;
`endif

        // clock/reset
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive_fields(mkv(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_inst",  64'(bus.out_inst),  64'd0);
        check("rst_out_err",   64'(bus.out_err),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // single words, then back-to-back pairs, all with latency checked
        send(addi, 32'h0051_0093, 1'b0);
        drain();
        send(sw,  32'h0051_2423, 1'b0);
        send(lui, 32'h1234_51B7, 1'b0);
        send(beq, 32'hFE00_0EE3, 1'b0);
        send(jal, 32'h0010_00EF, 1'b0);
        send(add, 32'h0020_81B3, 1'b0);
        send(sub, 32'h4020_81B3, 1'b0);
        send(addi_neg, 32'hFFF0_0093, 1'b0);
        drain();

        // immediate boundary and invalid formats
        send(addi_big, big_inst, big_err);
        send(fmt6, 32'h0, 1'b1);
        send(fmt7, 32'h0, 1'b1);
        drain();

        // backpressure: two accepted, third refused while output stalls
        check_lat     = 1'b0;
        bus.out_ready = 1'b0;
        send(addi, 32'h0051_0093, 1'b0);
        send(li2,  32'h0010_0113, 1'b0);
        drive_fields(li3);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_head", 64'({bus.out_valid, bus.out_inst}), 64'({1'b1, 32'h0051_0093}));
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(li3, 32'h0020_0193, 1'b0);
        drain();

        // stream under an irregular ready pattern
        pat = 12'b1011_0010_1101;
        fork
            begin
                send(jal, 32'h0010_00EF, 1'b0);
                send(beq, 32'hFE00_0EE3, 1'b0);
                send(fmt6, 32'h0, 1'b1);
                send(sw,  32'h0051_2423, 1'b0);
                send(add, 32'h0020_81B3, 1'b0);
                send(lui, 32'h1234_51B7, 1'b0);
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    bus.out_ready = pat[i];
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // asynchronous reset with both stages full
        bus.out_ready = 1'b0;
        send(sw,  32'h0051_2423, 1'b0);
        send(lui, 32'h1234_51B7, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_out_inst",  64'(bus.out_inst),  64'd0);
        check("async_in_ready",  64'(bus.in_ready),  64'd1);
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        check_lat     = 1'b1;
        @(posedge clk);
        #1;
        send(addi, 32'h0051_0093, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
